wb_port_arbiter: RTL

- Shares the single register-file write port (we3/a3/wd3) between the pipeline writeback stage and the multi-cycle mul/div unit.
- Holds one completed mul/div result in a 1-entry buffer and drains it into idle writeback slots.
- Forces a drain, stalling the pipeline writeback for one cycle, once the buffered result has waited MAXWAIT cycles.
- Sits between the writeback result mux, the mul/div unit, the register file and the hazard unit.

---
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between
// the writeback stage and a one-entry mul/div result buffer.
module wb_port_arbiter #(
  parameter int W       = 32,
  parameter int AW      = 5,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwriteW,
  input  logic [AW-1:0] rdW,
  input  logic [W-1:0]  resultW,
  input  logic          md_valid,
  input  logic [AW-1:0] md_rd,
  input  logic [W-1:0]  md_result,
  output logic          md_ready,
  output logic          we3,
  output logic [AW-1:0] a3,
  output logic [W-1:0]  wd3,
  output logic          stallW,
  output logic          md_pending,
  output logic [AW-1:0] md_pending_rd
);

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  logic          buf_valid;
  logic [AW-1:0] buf_rd;
  logic [W-1:0]  buf_data;
  logic [3:0]    wait_cnt;

  logic pipe_wr;
  logic buf_live;
  logic frc;
  logic accept;
  logic drain;
  logic bump;

  assign pipe_wr  = regwriteW && (rdW != '0);
  assign buf_live = buf_valid && (buf_rd != '0);
  assign frc      = buf_live && (wait_cnt >= MAXW);

  // Accept and drain never coincide: accept needs an empty buffer.
  assign md_ready = !buf_valid;
  assign accept   = md_valid && md_ready;

  // A buffered x0 result is dropped on its first cycle.
  assign drain = buf_valid &&
                 ((buf_rd == '0) || frc || !pipe_wr);
  assign bump  = buf_live && pipe_wr && !frc;

  assign md_pending    = buf_valid;
  assign md_pending_rd = buf_rd;

  // Grant the write port: aged buffer, then pipeline, then buffer.
  always_comb begin
    we3    = 1'b0;
    a3     = '0;
    wd3    = '0;
    stallW = 1'b0;
    if (rst) begin
      we3    = 1'b0;
    end else if (frc) begin
      we3    = 1'b1;
      a3     = buf_rd;
      wd3    = buf_data;
      stallW = pipe_wr;
    end else if (pipe_wr) begin
      we3    = 1'b1;
      a3     = rdW;
      wd3    = resultW;
    end else if (buf_live) begin
      we3    = 1'b1;
      a3     = buf_rd;
      wd3    = buf_data;
    end
  end

  // Buffer fill, drain and blocked-cycle ageing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
      wait_cnt  <= '0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_rd    <= md_rd;
      buf_data  <= md_result;
      wait_cnt  <= '0;
    end else if (drain) begin
      buf_valid <= 1'b0;
      wait_cnt  <= '0;
    end else if (bump) begin
      if (wait_cnt != 4'hF)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule
